// File: rtl/ctrl_sync_pkg.sv
// Shared types and defaults for the receive-side control-pulse phase recovery.
package ctrl_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } sync_state_e;

  localparam int DEF_PERIOD = 16;
  localparam int DEF_POS_A  = 7;
  localparam int DEF_POS_B  = 12;
  localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/pulse_gap_meter.sv
// Cycles since the last ctrl pulse, saturating at PERIOD ("no pulse seen").
module pulse_gap_meter
  import ctrl_sync_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int GW     = $clog2(DEF_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctrl_in,
  output logic [GW-1:0] gap
);

  localparam logic [GW-1:0] GAP_MAX = GW'(PERIOD);

  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    gap_d = gap_q;
    if (ctrl_in)
      gap_d = GW'(1);
    else if (gap_q < GAP_MAX)
      gap_d = gap_q + 1'b1;
    else
      gap_d = GAP_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= GAP_MAX;
    else        gap_q <= gap_d;
  end

  assign gap = gap_q;

endmodule

// File: rtl/ctrl_pulse_sync.sv
// Recovers the generator frame phase from the ctrl pulse stream: hunt, verify, lock,
// with per-cycle mismatch reporting and loss of lock after sustained bad frames.
module ctrl_pulse_sync
  import ctrl_sync_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int POS_A       = DEF_POS_A,
  parameter int POS_B       = DEF_POS_B,
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_FRAMES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ctrl_in,
  output logic                      locked,
  output logic [$clog2(PERIOD)-1:0] frame_pos,
  output logic                      frame_start,
  output logic                      err,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam int W    = $clog2(PERIOD);
  localparam int GW   = $clog2(PERIOD + 1);
  localparam int FMAX = (LOCK_FRAMES > LOSS_FRAMES) ? LOCK_FRAMES : LOSS_FRAMES;
  localparam int CW   = $clog2(FMAX + 1);

  localparam logic [GW-1:0] TRIG_GAP = GW'(POS_B - POS_A);
  localparam logic [W-1:0]  POS_A_L  = W'(POS_A);
  localparam logic [W-1:0]  POS_B_L  = W'(POS_B);
  localparam logic [W-1:0]  ACQ_POS  = W'((POS_B + 1) % PERIOD);
  localparam logic [W-1:0]  LAST_POS = W'(PERIOD - 1);
  localparam logic [CW-1:0] LOCK_L   = CW'(LOCK_FRAMES);
  localparam logic [CW-1:0] LOSS_L   = CW'(LOSS_FRAMES);

  sync_state_e          state_q, state_d;
  logic [W-1:0]         pos_q, pos_d;
  logic [CW-1:0]        good_q, good_d;
  logic [CW-1:0]        bad_q, bad_d;
  logic                 dirty_q, dirty_d;
  logic                 err_q, err_d;
  logic                 locked_q, locked_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [GW-1:0]        gap;
  logic                 expected, mismatch, wrap;

  pulse_gap_meter #(
    .PERIOD (PERIOD),
    .GW     (GW)
  ) u_gap (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_in (ctrl_in),
    .gap     (gap)
  );

  always_comb begin
    expected  = (pos_q == POS_A_L) || (pos_q == POS_B_L);
    mismatch  = (state_q != HUNT) && (ctrl_in != expected);
    wrap      = (pos_q == LAST_POS);

    state_d   = state_q;
    pos_d     = wrap ? '0 : pos_q + 1'b1;
    good_d    = good_q;
    bad_d     = bad_q;
    dirty_d   = wrap ? 1'b0 : (dirty_q | mismatch);
    err_d     = mismatch;
    err_cnt_d = (mismatch && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;

    unique case (state_q)
      HUNT: begin
        pos_d   = '0;
        dirty_d = 1'b0;
        if (ctrl_in && (gap == TRIG_GAP)) begin
          state_d = VERIFY;
          pos_d   = ACQ_POS;
          good_d  = '0;
          bad_d   = '0;
        end
      end
      VERIFY: begin
        // A mismatch on the wrap cycle must beat promotion, so test it first.
        if (mismatch) begin
          state_d = HUNT;
          pos_d   = '0;
        end else if (wrap) begin
          good_d = good_q + 1'b1;
          if (good_d == LOCK_L) state_d = LOCKED;
        end
      end
      LOCKED: begin
        // The frame's own wrap-cycle mismatch is folded in before judging it.
        if (wrap) begin
          if (dirty_q || mismatch) begin
            bad_d = bad_q + 1'b1;
            if (bad_d == LOSS_L) begin
              state_d = HUNT;
              pos_d   = '0;
            end
          end else begin
            bad_d = '0;
          end
        end
      end
      default: begin
        state_d = HUNT;
        pos_d   = '0;
      end
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      pos_q     <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      dirty_q   <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      dirty_q   <= dirty_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked      = locked_q;
  assign frame_pos   = pos_q;
  assign frame_start = (state_q != HUNT) && (pos_q == '0);
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: doc/ctrl_pulse_sync.md
# ctrl_pulse_sync

Receive-side companion to the frame control-pulse generator. The generator runs a free-running 16-state frame counter and emits a single-cycle `ctrl` pulse at counts 7 and 12. This block samples that pulse stream and recovers the generator's frame phase. It declares lock after consistent frames, reports per-cycle pattern errors and drops lock on sustained errors. Downstream logic uses `frame_pos` and `frame_start` in place of a direct copy of the generator counter.

## Interface
- `PERIOD`, 16: frame length in cycles. Position width is W = $clog2(PERIOD).
- `POS_A`, 7: first pulse position. Requires 0 ≤ POS_A < POS_B < PERIOD.
- `POS_B`, 12: second pulse position. Requires (POS_B−POS_A) ≠ PERIOD−(POS_B−POS_A).
- `LOCK_FRAMES`, 2: number of consecutive clean frame wraps in VERIFY needed to reach LOCKED.
- `LOSS_FRAMES`, 2: number of consecutive bad frames in LOCKED that return the block to HUNT.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ctrl_in`  in  1  pulse stream, synchronous to `clk`.
- `locked`  out  1  high while state = LOCKED.
- `frame_pos`  out  W  predicted generator count for the current cycle; 0 in HUNT.
- `frame_start`  out  1  high when state ≠ HUNT and frame_pos = 0.
- `err`  out  1  one-cycle pulse, registered, one cycle after a mismatched sample.
- `err_cnt`  out  8  saturating count of mismatched cycles; cleared only by reset.

## Operation
- Gap tracker:
  - `gap` runs in all states and resets to PERIOD (meaning "no pulse seen").
  - On `ctrl_in`=1, `gap` ← 1.
  - Otherwise `gap` ← min(gap+1, PERIOD).
- Expected value: exp = (frame_pos = POS_A) or (frame_pos = POS_B). A mismatch is `ctrl_in` ≠ exp, evaluated only in VERIFY and LOCKED.
- HUNT:
  - Trigger: `ctrl_in`=1 while gap = POS_B−POS_A.
  - On trigger: frame_pos ← POS_B+1 (mod PERIOD), clear the good and bad frame counters, go to VERIFY.
  - Gaps of any other length are ignored.
- frame_pos in VERIFY and LOCKED: increments every cycle and wraps PERIOD−1 → 0. A "wrap" is a cycle where frame_pos = PERIOD−1.
- VERIFY:
  - Any mismatch → HUNT on that edge.
  - Each clean wrap increments the good counter. On reaching LOCK_FRAMES → LOCKED.
  - The partial first frame counts as a frame.
- LOCKED:
  - A frame is bad if it contains ≥1 mismatch.
  - At a wrap, a bad frame increments the bad counter; on reaching LOSS_FRAMES → HUNT.
  - At a wrap, a clean frame clears the bad counter.
- Every mismatch gives `err`=1 next cycle and `err_cnt`+1, saturating at 255.
- On entry to HUNT, frame_pos ← 0. `gap` is not disturbed, so the block can re-acquire immediately.

## Timing
- Reset (asynchronous, immediate, no clock needed):
  - State HUNT, gap = PERIOD, frame_pos = 0.
  - locked, err, frame_start, err_cnt all 0; internal counters 0.
- Acquisition: trigger sample in cycle t → frame_pos = POS_B+1 in cycle t+1, aligned to the generator count.
- `locked`, `err`, `frame_pos` are registered. `frame_start` is a decode of registered state only.
- Mismatch on a wrap cycle in VERIFY: HUNT wins over promotion.
- Mismatch on a wrap cycle in LOCKED: that frame counts as bad at the same edge.
- Trigger condition on the same cycle the block falls back to HUNT: ignored. Acquisition needs a later pulse pair.
- Reset asserted mid-frame: outputs clear asynchronously. Operation resumes in HUNT on the first edge after deassertion.

## Structure
- Package `ctrl_sync_pkg`:
  - State encoding: HUNT = 2'b00, VERIFY = 2'b01, LOCKED = 2'b10.
  - Default constants for PERIOD, POS_A, POS_B.
  - ERR_CNT_W = 8.
- Sub-module `pulse_gap_meter`: the saturating gap counter. Inputs clk, rst_n, ctrl_in; output gap.
- The FSM, phase counter, frame counters and error logic live in the top module.

## Test plan
All scenarios use the defaults.

- Reset, then a generator starting at count 0 in cycle 0 (pulses in cycles 7, 12, 23, 28, …):
  - frame_pos = 13 in cycle 13.
  - Wraps at cycles 15 and 31, so locked = 1 from cycle 32.
  - frame_start = 1 in cycles 16, 32, 48.
  - err never asserts.
- While locked, suppress one pulse at count 7:
  - err = 1 one cycle later, err_cnt = 1.
  - locked stays 1; the bad counter clears at the next clean wrap.
- While locked, suppress the count-12 pulse in two consecutive frames:
  - locked = 0 in the cycle after the second frame's count-15 cycle.
  - frame_pos = 0 in that cycle.
- Shift the generator phase by +3 while locked:
  - err pulses appear and locked drops after 2 bad frames.
  - The block re-acquires on the next 5-gap pair and locked returns after 2 clean wraps.
- Pulses every 11 cycles only: the block stays in HUNT and locked never rises. A 5-gap pair followed by a wrong pattern: VERIFY → HUNT on the first mismatch, locked never rises.
- Drop rst_n mid-frame while locked with err_cnt > 0: all outputs are 0 before the next clk edge. Release rst_n: the block re-acquires as in the first scenario.
